mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, fixed-latency memory access, one-cycle done pulse.
// Define MEM_ARBITER_FIXED_PRIORITY_EN to make requester 0 always win simultaneous requests.
module mem_arbiter #(
  parameter int OPERAND_LENGTH = 31,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [OPERAND_LENGTH:0] req0_addr,
  input  logic [OPERAND_LENGTH:0] req0_wdata,
  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [OPERAND_LENGTH:0] req1_addr,
  input  logic [OPERAND_LENGTH:0] req1_wdata,
  output logic                    req0_ready,
  output logic                    req1_ready,
  output logic                    req0_done,
  output logic                    req1_done,
  output logic [OPERAND_LENGTH:0] rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [OPERAND_LENGTH:0] mem_addr,
  output logic [OPERAND_LENGTH:0] mem_wdata,
  input  logic [OPERAND_LENGTH:0] mem_rdata,
  output logic                    busy
);

  // Handshake: a requester holds valid and payload stable until it sees ready;
  // ready is a same-cycle, one-cycle pulse issued only while IDLE, to at most one requester.
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic [2:0] count;
  logic       owner;
  logic       grant0;
  logic       grant1;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
  assign grant1 = req1_valid && !req0_valid;
`else
  logic last_owner;
  // On a tie the requester that did not win last time goes next.
  assign grant1 = req1_valid && (!req0_valid || !last_owner);
`endif
  assign grant0 = req0_valid && !grant1;

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 3'd0;
      owner     <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
      last_owner <= 1'b1;
`endif
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state     <= ACCESS;
            count     <= LAT_M1;
            owner     <= grant1;
            mem_en    <= 1'b1;
            mem_we    <= grant1 ? req1_write : req0_write;
            mem_addr  <= grant1 ? req1_addr  : req0_addr;
            mem_wdata <= grant1 ? req1_wdata : req0_wdata;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
            last_owner <= grant1;
`endif
          end
        end
        ACCESS: begin
          if (count == 3'd0) begin
            // mem_we still holds the latched direction of this transaction.
            if (!mem_we) rdata <= mem_rdata;
            state     <= DONE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            req0_done <= !owner;
            req1_done <= owner;
          end else begin
            count <= count - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences, random traffic vs a transaction model.
module tb_mem_arbiter;

  localparam int LAT = 2;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;

  logic        ready0, ready1, done0, done1, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        x1_ready0, x1_ready1, x1_done0, x1_done1, x1_mem_en, x1_mem_we, x1_busy;
  logic [31:0] x1_rdata, x1_mem_addr, x1_mem_wdata;
  logic [31:0] x1_mem_rdata = '0;

  logic        use_phys = 1'b0;
  logic [31:0] tb_rdata = '0;
  logic [31:0] phys [8];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.OPERAND_LENGTH(31), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(ready0), .req1_ready(ready1), .req0_done(done0), .req1_done(done1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.OPERAND_LENGTH(31), .MEM_LATENCY(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(x1_ready0), .req1_ready(x1_ready1), .req0_done(x1_done0), .req1_done(x1_done1),
    .rdata(x1_rdata), .mem_en(x1_mem_en), .mem_we(x1_mem_we), .mem_addr(x1_mem_addr),
    .mem_wdata(x1_mem_wdata), .mem_rdata(x1_mem_rdata), .busy(x1_busy)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  // Small word memory behind the main DUT; it only changes when the DUT writes it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) phys[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      phys[mem_addr[4:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = use_phys ? phys[mem_addr[4:2]] : tb_rdata;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          do_rst;
    bit          v0, w0;
    logic [31:0] a0, d0;
    bit          v1, w1;
    logic [31:0] a1, d1;
    logic [31:0] mem;
    bit          own_rr, own_fp;
    logic [31:0] rd_rr, rd_fp;
  } vec_t;

  task automatic apply_row(input int idx, input vec_t v);
    bit          own;
    logic [31:0] exp_rd, exp_a, exp_d;
    bit          exp_w;
    if (v.do_rst) do_reset();
    own    = FP ? v.own_fp : v.own_rr;
    exp_rd = FP ? v.rd_fp  : v.rd_rr;
    exp_a  = own ? v.a1 : v.a0;
    exp_d  = own ? v.d1 : v.d0;
    exp_w  = own ? v.w1 : v.w0;
    tb_rdata   = v.mem;
    req0_valid = v.v0; req0_write = v.w0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_write = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
    @(negedge clk);
    check($sformatf("row%0d_ready0", idx), 32'(ready0), 32'(!own));
    check($sformatf("row%0d_ready1", idx), 32'(ready1), 32'(own));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("row%0d_c%0d_mem_en", idx, k), 32'(mem_en), 32'd1);
      check($sformatf("row%0d_c%0d_mem_we", idx, k), 32'(mem_we), 32'(exp_w));
      check($sformatf("row%0d_c%0d_mem_addr", idx, k), mem_addr, exp_a);
      check($sformatf("row%0d_c%0d_mem_wdata", idx, k), mem_wdata, exp_d);
      check($sformatf("row%0d_c%0d_busy", idx, k), 32'(busy), 32'd1);
      check($sformatf("row%0d_c%0d_no_done", idx, k), 32'(done0 | done1), 32'd0);
      tick();
    end
    @(negedge clk);
    check($sformatf("row%0d_done0", idx), 32'(done0), 32'(!own));
    check($sformatf("row%0d_done1", idx), 32'(done1), 32'(own));
    check($sformatf("row%0d_rdata", idx), rdata, exp_rd);
    check($sformatf("row%0d_done_mem_en", idx), 32'(mem_en | mem_we), 32'd0);
    tick();
    @(negedge clk);
    check($sformatf("row%0d_after_done", idx), 32'(done0 | done1), 32'd0);
    check($sformatf("row%0d_after_busy", idx), 32'(busy), 32'd0);
    tick();
  endtask

  // Transaction-level reference state for the random phase.
  bit          m_active;
  int          m_age;
  bit          m_owner, m_write, m_last;
  logic [31:0] m_addr, m_wdata, m_rdata, m_load_val;
  logic [31:0] model_mem [8];

  task automatic model_step(output bit acc0, output bit acc1);
    bit exp_r0, exp_r1, exp_en, win, any;
    exp_r0 = 1'b0; exp_r1 = 1'b0; win = 1'b0; any = 1'b0;
    if (!m_active) begin
      if (req0_valid && req1_valid) begin
        any = 1'b1;
        win = FP ? 1'b0 : !m_last;
      end else if (req0_valid || req1_valid) begin
        any = 1'b1;
        win = req1_valid;
      end
      if (any) begin
        m_active = 1'b1;
        m_age    = 0;
        m_owner  = win;
        m_last   = win;
        m_write  = win ? req1_write : req0_write;
        m_addr   = win ? req1_addr  : req0_addr;
        m_wdata  = win ? req1_wdata : req0_wdata;
        if (m_write) model_mem[m_addr[4:2]] = m_wdata;
        else         m_load_val = model_mem[m_addr[4:2]];
        if (win) exp_r1 = 1'b1; else exp_r0 = 1'b1;
      end
    end else begin
      m_age++;
    end
    exp_en = m_active && m_age >= 1 && m_age <= LAT;
    check("rnd_ready0", 32'(ready0), 32'(exp_r0));
    check("rnd_ready1", 32'(ready1), 32'(exp_r1));
    check("rnd_busy", 32'(busy), 32'(m_active && m_age > 0));
    check("rnd_mem_en", 32'(mem_en), 32'(exp_en));
    check("rnd_mem_we", 32'(mem_we), 32'(exp_en && m_write));
    if (exp_en) begin
      check("rnd_mem_addr", mem_addr, m_addr);
      check("rnd_mem_wdata", mem_wdata, m_wdata);
    end
    if (m_active && m_age == LAT + 1 && !m_write) m_rdata = m_load_val;
    check("rnd_done0", 32'(done0), 32'(m_active && m_age == LAT + 1 && !m_owner));
    check("rnd_done1", 32'(done1), 32'(m_active && m_age == LAT + 1 && m_owner));
    check("rnd_rdata", rdata, m_rdata);
    if (m_active && m_age == LAT + 1) m_active = 1'b0;
    acc0 = ready0;
    acc1 = ready1;
  endtask

  task automatic new_req(input bit which);
    logic [31:0] a;
    a = {$urandom()} & 32'hFFFF_FFFC;
    if (!which) begin
      req0_valid = 1'b1; req0_write = 1'($urandom_range(0, 1));
      req0_addr = a; req0_wdata = $urandom();
    end else begin
      req1_valid = 1'b1; req1_write = 1'($urandom_range(0, 1));
      req1_addr = a; req1_wdata = $urandom();
    end
  endtask

  initial begin
    vec_t        vecs [6];
    logic [31:0] exp_q [$];
    int          seen, dcount;
    bit          acc0, acc1;

    vecs[0] = '{1, 1, 0, 32'h10, 32'h0,       0, 0, 32'h0,  32'h0,    32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{0, 0, 0, 32'h0,  32'h0,       1, 1, 32'h20, 32'h1234, 32'hBAD0BAD0, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1, 1, 0, 32'h30, 32'hAAAA0000, 1, 1, 32'h40, 32'h5555, 32'h11111111, 0, 0, 32'h11111111, 32'h11111111};
    vecs[3] = '{0, 1, 1, 32'h34, 32'h77,       1, 0, 32'h44, 32'hBBBB, 32'h22222222, 1, 0, 32'h22222222, 32'h11111111};
    vecs[4] = '{0, 1, 0, 32'h38, 32'hC0,       1, 0, 32'h48, 32'hC1,   32'h33333333, 0, 0, 32'h33333333, 32'h33333333};
    vecs[5] = '{0, 0, 0, 32'h0,  32'h0,       1, 0, 32'h4C, 32'hC2,   32'h44444444, 1, 1, 32'h44444444, 32'h44444444};

    // Reset values
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en | mem_we), 32'd0);
    check("rst_done", 32'(done0 | done1), 32'd0);
    check("rst_ready", 32'(ready0 | ready1), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) apply_row(i, vecs[i]);

    // Back-to-back: req0 held valid, ready every LAT+2 cycles
    do_reset();
    tb_rdata = 32'h5A5A5A5A;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h8; req0_wdata = 32'h0;
    for (int c = 0; c <= 3 * (LAT + 2); c += LAT + 2) exp_q.push_back(32'(c));
    seen = 0;
    for (int c = 0; c < 3 * (LAT + 2) + 2; c++) begin
      @(negedge clk);
      if (ready0) begin
        if (exp_q.size() == 0) check("b2b_extra_ready", 32'(c), 32'hFFFF_FFFF);
        else check("b2b_ready_cycle", 32'(c), exp_q.pop_front());
        seen++;
      end
      tick();
    end
    check("b2b_ready_count", 32'(seen), 32'd4);
    req0_valid = 1'b0;

    // Reset in the second ACCESS cycle aborts the store
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h1C; req0_wdata = 32'h600D;
    @(negedge clk);
    check("abort_ready0", 32'(ready0), 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("abort_c1_mem_en", 32'(mem_en), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_c2_mem_en", 32'(mem_en), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    dcount = 0;
    for (int c = 0; c < 5; c++) begin
      if (done0 || done1 || mem_we) dcount++;
      tick();
      @(negedge clk);
    end
    check("abort_no_done_or_we", 32'(dcount), 32'd0);
    tick();

    // MEM_LATENCY=1 instance: load
    do_reset();
    x1_mem_rdata = 32'hCAFEF00D;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h14; req0_wdata = 32'h0;
    @(negedge clk);
    check("lat1_ready0", 32'(x1_ready0), 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("lat1_c1_mem_en", 32'(x1_mem_en), 32'd1);
    check("lat1_c1_mem_addr", x1_mem_addr, 32'h14);
    check("lat1_c1_no_done", 32'(x1_done0), 32'd0);
    tick();
    @(negedge clk);
    check("lat1_c2_mem_en", 32'(x1_mem_en), 32'd0);
    check("lat1_c2_done0", 32'(x1_done0), 32'd1);
    check("lat1_c2_rdata", x1_rdata, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    check("lat1_c3_done0", 32'(x1_done0), 32'd0);
    check("lat1_c3_busy", 32'(x1_busy), 32'd0);
    tick();

    // Random traffic against the transaction model
    use_phys = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = init_val(i);
    m_active = 1'b0; m_age = 0; m_last = 1'b1; m_owner = 1'b0; m_write = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_load_val = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      model_step(acc0, acc1);
      tick();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 99) < 45) new_req(1'b0);
      if (!req1_valid && $urandom_range(0, 99) < 45) new_req(1'b1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
